demux1_4: RTL and testbench



---
 rtl/demux1_4_pkg.sv | 6 +
 rtl/demux1_2.sv | 14 +
 rtl/demux1_4.sv | 69 ++++++
 tb/tb_demux1_4.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/demux1_4_pkg.sv
// rtl/demux1_4_pkg.sv - shared constants for the 1:4 demux slice
package demux1_4_pkg;

  localparam int NUM_OUT = 4;

endpackage

// File: rtl/demux1_2.sv
// rtl/demux1_2.sv - 1:2 demux stage; the unselected leg is driven to zero
module demux1_2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);

  assign y0 = sel ? '0 : i;
  assign y1 = sel ? i  : '0;

endmodule

// File: rtl/demux1_4.sv
// rtl/demux1_4.sv - 1:4 demux built from a 1:2 tree with an optional output register
module demux1_4
  import demux1_4_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel0,
  input  logic             sel1,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);

  logic [WIDTH-1:0] lo_br;
  logic [WIDTH-1:0] hi_br;
  logic [WIDTH-1:0] d [NUM_OUT];
  logic [WIDTH-1:0] q [NUM_OUT];

  // sel1 picks the half, sel0 picks the leg within it
  demux1_2 #(.WIDTH(WIDTH)) u_stage1 (
    .sel (sel1),
    .i   (i),
    .y0  (lo_br),
    .y1  (hi_br)
  );

  demux1_2 #(.WIDTH(WIDTH)) u_stage2_lo (
    .sel (sel0),
    .i   (lo_br),
    .y0  (d[0]),
    .y1  (d[1])
  );

  demux1_2 #(.WIDTH(WIDTH)) u_stage2_hi (
    .sel (sel0),
    .i   (hi_br),
    .y0  (d[2]),
    .y1  (d[3])
  );

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < NUM_OUT; k++) q[k] <= '0;
        end else begin
          for (int k = 0; k < NUM_OUT; k++) q[k] <= d[k];
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      always_comb begin
        for (int k = 0; k < NUM_OUT; k++) q[k] = d[k];
      end
    end
  endgenerate

  assign y0 = q[0];
  assign y1 = q[1];
  assign y2 = q[2];
  assign y3 = q[3];

endmodule

// File: tb/tb_demux1_4.sv
// tb/tb_demux1_4.sv - self-checking bench for demux1_4 (registered and combinational builds)
module tb_demux1_4;

  logic       clk;
  logic       rst_n;
  logic       sel0;
  logic       sel1;
  logic       i1;
  logic [7:0] i8;
  logic       a0, a1, a2, a3;
  logic [7:0] c0, c1, c2, c3;
  logic [7:0] r0, r1, r2, r3;

  int checks = 0;
  int errors = 0;

  demux1_4 #(.WIDTH(1), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1), .i(i1),
    .y0(a0), .y1(a1), .y2(a2), .y3(a3)
  );

  demux1_4 #(.WIDTH(8), .REG_OUT(0)) dutc (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1), .i(i8),
    .y0(c0), .y1(c1), .y2(c2), .y3(c3)
  );

  demux1_4 #(.WIDTH(8), .REG_OUT(1)) dutr (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1), .i(i8),
    .y0(r0), .y1(r1), .y2(r2), .y3(r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s0;
    logic       s1;
    logic       d;
    logic [3:0] exp;
  } vec_t;

  // Reference: output number {sel1,sel0} carries the data, the rest carry zero
  function automatic logic [31:0] model8(input logic s1, input logic s0, input logic [7:0] d);
    logic [7:0] y [4];
    int idx;
    idx = 2 * int'(s1) + int'(s0);
    for (int k = 0; k < 4; k++) y[k] = (k == idx) ? d : 8'h00;
    return {y[3], y[2], y[1], y[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] n1();
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [8];
  logic [31:0] exp_r;

  initial begin
    vecs[0] = '{s0: 1'b0, s1: 1'b0, d: 1'b0, exp: 4'b0000};
    vecs[1] = '{s0: 1'b0, s1: 1'b0, d: 1'b1, exp: 4'b0001};
    vecs[2] = '{s0: 1'b1, s1: 1'b0, d: 1'b0, exp: 4'b0000};
    vecs[3] = '{s0: 1'b1, s1: 1'b0, d: 1'b1, exp: 4'b0010};
    vecs[4] = '{s0: 1'b0, s1: 1'b1, d: 1'b0, exp: 4'b0000};
    vecs[5] = '{s0: 1'b0, s1: 1'b1, d: 1'b1, exp: 4'b0100};
    vecs[6] = '{s0: 1'b1, s1: 1'b1, d: 1'b0, exp: 4'b0000};
    vecs[7] = '{s0: 1'b1, s1: 1'b1, d: 1'b1, exp: 4'b1000};

    // Reset with a live selection: outputs must be zero before any edge
    rst_n = 1'b0;
    sel0  = 1'b1;
    sel1  = 1'b1;
    i1    = 1'b1;
    i8    = 8'hFF;
    #2;
    check("reset_w1", {28'd0, n1()}, 32'h0);
    check("reset_w8", {r3, r2, r1, r0}, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("release_no_edge", {28'd0, n1()}, 32'h0);
    tick();
    check("release_first_edge", {28'd0, n1()}, 32'h8);

    for (int v = 0; v < 8; v++) begin
      sel0 = vecs[v].s0;
      sel1 = vecs[v].s1;
      i1   = vecs[v].d;
      tick();
      check($sformatf("sweep_%0d", v), {28'd0, n1()}, {28'd0, vecs[v].exp});
    end

    // One-hot walk with select changing every cycle
    i1 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel0 = s[0];
      sel1 = s[1];
      tick();
      check($sformatf("walk_%0d", s), {28'd0, n1()}, 32'h1 << s);
    end

    // Asynchronous reset pulse between edges
    sel0 = 1'b0;
    sel1 = 1'b1;
    i1   = 1'b1;
    tick();
    check("pre_reset_y2", {28'd0, n1()}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_clear", {28'd0, n1()}, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("after_release_hold", {28'd0, n1()}, 32'h0);
    tick();
    check("after_release_edge", {28'd0, n1()}, 32'h4);

    // Combinational build: zero latency
    i8   = 8'hA5;
    sel0 = 1'b1;
    sel1 = 1'b0;
    #1;
    check("comb_a5_sel01", {c3, c2, c1, c0}, 32'h0000A500);

    // Randomised traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      sel0 = 1'($urandom);
      sel1 = 1'($urandom);
      i8   = 8'($urandom);
      exp_r = model8(sel1, sel0, i8);
      #1;
      check("rand_comb", {c3, c2, c1, c0}, exp_r);
      tick();
      check("rand_reg", {r3, r2, r1, r0}, exp_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
